seg_scan_driver: RTL

- Downstream display stage for the mode-selectable 4-bit counter.
- Takes the counter's 4-bit binary value (0..15) and splits it into two decimal digits.
- Drives a 2-digit multiplexed seven-segment display with a programmable scan rate.
- Also flags counter wrap-around with a single-cycle pulse.
- Latches the displayed value only at frame boundaries, so a digit pair is never torn.

---
 rtl/seg_scan_pkg.sv | 18 +
 rtl/seg7_encode.sv | 16 +
 rtl/seg_scan_driver.sv | 85 ++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
package seg_scan_pkg;

    typedef enum logic {
        S_UNITS = 1'b0,
        S_TENS  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [1:0] DIGIT_OFF = 2'b11;

    // gfedcba patterns, entry 0 is the rightmost element
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD to seven-segment (gfedcba, active-high) encoder.
module seg7_encode
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_LUT[bcd];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment scan driver with frame-aligned value latch
// and wrap-pulse detect. Define SEG_SCAN_LZB_EN to blank a leading zero tens digit.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DIV_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic [1:0] digit_sel,
    output logic       wrap_pulse
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(SCAN_DIV - 1);

    state_t           state;
    logic [DIV_W-1:0] prescaler;
    logic [3:0]       shadow;
    logic [3:0]       value_d;

    logic       tens;
    logic [3:0] units;
    logic [3:0] digit;
    logic [6:0] seg_next;

    always_comb begin
        tens  = (shadow >= 4'd10);
        units = tens ? (shadow - 4'd10) : shadow;
        digit = (state == S_TENS) ? {3'b000, tens} : units;
    end

    seg7_encode u_enc (
        .bcd (digit),
        .seg (seg_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            state      <= S_UNITS;
            shadow     <= value;
            value_d    <= 4'd0;
            seg        <= SEG_BLANK;
            digit_sel  <= DIGIT_OFF;
            wrap_pulse <= 1'b0;
        end else begin
            // value_d clears in reset, so the first compare after reset cannot fire
            value_d    <= value;
            wrap_pulse <= (value < value_d);

            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                state     <= (state == S_UNITS) ? S_TENS : S_UNITS;
                // end of the tens slot closes the frame: latch the next digit pair
                if (state == S_TENS) begin
                    shadow <= value;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (state == S_UNITS) begin
                seg       <= seg_next;
                digit_sel <= 2'b10;
            end else begin
`ifdef SEG_SCAN_LZB_EN
                if (!tens) begin
                    seg       <= SEG_BLANK;
                    digit_sel <= DIGIT_OFF;
                end else begin
                    seg       <= seg_next;
                    digit_sel <= 2'b01;
                end
`else
                seg       <= seg_next;
                digit_sel <= 2'b01;
`endif
            end
        end
    end

endmodule
